// File: rtl/sum_rest_pkg.sv
// Shared op encodings and signed range helpers for the sum/rest datapath.
package sum_rest_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    // Largest positive two's-complement value for a given width, low bits valid.
    function automatic logic [63:0] smax_val(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value for a given width, low bits valid.
    function automatic logic [63:0] smin_val(input int unsigned width);
        return 64'd0 - (64'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/sum_rest_core.sv
// Combinational WIDTH-bit signed add/sub with overflow detect.
// Clamps instead of wrapping when MOD_SUM_REST_SATURATE_EN is defined.
module sum_rest_core
    import sum_rest_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
);

    logic signed [WIDTH-1:0] raw;
    logic                    b_sign_eff;

    assign raw = sub ? (a - b) : (a + b);

    // Subtracting flips the effective sign of b, so one rule covers both ops.
    assign b_sign_eff = b[WIDTH-1] ^ sub;
    assign ovf        = (a[WIDTH-1] == b_sign_eff) && (raw[WIDTH-1] != a[WIDTH-1]);

`ifdef MOD_SUM_REST_SATURATE_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(smax_val(WIDTH));
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(smin_val(WIDTH));

    // On overflow the true result always carries the sign of a.
    assign y = !ovf ? raw : (a[WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
    assign y = raw;
`endif

endmodule

// File: rtl/mod_sum_rest_acc.sv
// Registered signed add/sub with accumulator, valid/ready output stage and
// overflow flags. Optional saturation via MOD_SUM_REST_SATURATE_EN.
module mod_sum_rest_acc
    import sum_rest_pkg::*;
#(
    parameter int                      WIDTH    = 6,
    parameter logic signed [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [1:0]              SEL,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [WIDTH-1:0] Y,
    output logic                    OF_SUM_REST,
    output logic                    OF_STICKY,
    input  logic                    CLR_OF
);

    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] core_a;
    logic signed [WIDTH-1:0] core_b;
    logic signed [WIDTH-1:0] core_y;
    logic                    core_ovf;
    logic                    op_acc;
    logic                    op_sub;
    logic                    accept;

    assign op_acc   = (SEL == OP_ACC_ADD) || (SEL == OP_ACC_SUB);
    assign op_sub   = (SEL == OP_SUB) || (SEL == OP_ACC_SUB);
    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // Accumulator ops use (ACC, A); plain ops use (A, B).
    assign core_a = op_acc ? acc_q : A;
    assign core_b = op_acc ? A : B;

    sum_rest_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (core_a),
        .b   (core_b),
        .sub (op_sub),
        .y   (core_y),
        .ovf (core_ovf)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Y           <= '0;
            OUT_VALID   <= 1'b0;
            OF_SUM_REST <= 1'b0;
            OF_STICKY   <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            if (accept) begin
                Y           <= core_y;
                OF_SUM_REST <= core_ovf;
                OUT_VALID   <= 1'b1;
                if (op_acc) begin
                    acc_q <= core_y;
                end
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            // A new overflow takes priority over a simultaneous clear.
            if (accept && core_ovf) begin
                OF_STICKY <= 1'b1;
            end else if (CLR_OF) begin
                OF_STICKY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_sum_rest_acc.sv
// Self-checking bench for mod_sum_rest_acc: directed scenarios with literal
// expectations followed by randomized traffic against an integer model.
module tb_mod_sum_rest_acc;

    localparam int W        = 6;
    localparam int ACC_INIT = 0;
    localparam int SMAX     = (1 << (W - 1)) - 1;
    localparam int SMIN     = -(1 << (W - 1));

`ifdef MOD_SUM_REST_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          sel;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] y;
    logic                of_sum_rest;
    logic                of_sticky;
    logic                clr_of;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_valid  = 0;
    int m_y      = 0;
    int m_of     = 0;
    int m_sticky = 0;
    int m_acc    = ACC_INIT;
    bit cmp_en   = 1'b0;

    mod_sum_rest_acc #(
        .WIDTH    (W),
        .ACC_INIT (W'(ACC_INIT))
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .SEL         (sel),
        .A           (a),
        .B           (b),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .Y           (y),
        .OF_SUM_REST (of_sum_rest),
        .OF_STICKY   (of_sticky),
        .CLR_OF      (clr_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: true result, then wrap or clamp.
    function automatic int wrap_w(input int v);
        int r;
        r = v & ((1 << W) - 1);
        if (r > SMAX) r = r - (1 << W);
        return r;
    endfunction

    always @(posedge clk) begin
        int lhs, rhs, tru, res;
        bit acc_op, ovf, accepted;
        if (rst) begin
            m_valid = 0; m_y = 0; m_of = 0; m_sticky = 0; m_acc = ACC_INIT;
        end else begin
            accepted = in_valid && (m_valid == 0 || out_ready);
            ovf      = 1'b0;
            if (accepted) begin
                acc_op = sel[1];
                lhs    = acc_op ? m_acc : int'(a);
                rhs    = acc_op ? int'(a) : int'(b);
                tru    = sel[0] ? lhs - rhs : lhs + rhs;
                ovf    = (tru > SMAX) || (tru < SMIN);
                if (ovf && SAT) res = (tru > 0) ? SMAX : SMIN;
                else            res = wrap_w(tru);
                m_y     = res;
                m_of    = ovf;
                m_valid = 1;
                if (acc_op) m_acc = res;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (accepted && ovf) m_sticky = 1;
            else if (clr_of)     m_sticky = 0;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", int'(out_valid), m_valid);
            check("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
            check("y", int'(y), m_y);
            check("of_sum_rest", int'(of_sum_rest), m_of);
            check("of_sticky", int'(of_sticky), m_sticky);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input int av, input int bv);
        in_valid = v;
        sel      = s;
        a        = W'(av);
        b        = W'(bv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = 2'b00; a = '0; b = '0;
        out_ready = 1'b1; clr_of = 1'b0;
        cycle();
        cycle();
        cmp_en = 1'b1;
        rst = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_y", int'(y), 0);
        check("rst_of", int'(of_sum_rest), 0);
        check("rst_sticky", int'(of_sticky), 0);

        // 1: 20 + 15 overflows
        drive(1, 2'b00, 20, 15); cycle();
        check("p1_valid", int'(out_valid), 1);
        check("p1_y", int'(y), SAT ? 31 : -29);
        check("p1_of", int'(of_sum_rest), 1);
        check("p1_sticky", int'(of_sticky), 1);

        // 2: -20 - 15 overflows, then 5 - (-3) does not
        drive(1, 2'b01, -20, 15); cycle();
        check("p2_y", int'(y), SAT ? -32 : 29);
        check("p2_of", int'(of_sum_rest), 1);
        drive(1, 2'b01, 5, -3); cycle();
        check("p2b_y", int'(y), 8);
        check("p2b_of", int'(of_sum_rest), 0);
        check("p2b_sticky", int'(of_sticky), 1);

        // 3: accumulate 10 three times, then 5 overflows
        drive(1, 2'b10, 10, 0); cycle();
        check("p3_y10", int'(y), 10);
        cycle();
        check("p3_y20", int'(y), 20);
        cycle();
        check("p3_y30", int'(y), 30);
        drive(1, 2'b10, 5, 0); cycle();
        check("p3_wrap", int'(y), SAT ? 31 : -29);
        check("p3_of", int'(of_sum_rest), 1);
        drive(1, 2'b00, 1, 1); cycle();
        check("p3_add", int'(y), 2);
        drive(1, 2'b10, 0, 0); cycle();
        check("p3_acc_kept", int'(y), SAT ? 31 : -29);

        // 4: backpressure
        drive(1, 2'b00, 3, 4); cycle();
        check("p4_y", int'(y), 7);
        out_ready = 1'b0;
        drive(1, 2'b00, 9, 9);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("p4_hold_y", int'(y), 7);
            check("p4_hold_valid", int'(out_valid), 1);
            check("p4_hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1; cycle();
        check("p4_release_y", int'(y), 18);
        drive(0, 2'b00, 0, 0); cycle();
        check("p4_drain", int'(out_valid), 0);

        // 5: clear vs. set priority
        clr_of = 1'b1; cycle();
        check("p5_clr", int'(of_sticky), 0);
        drive(1, 2'b00, 20, 15); cycle();
        check("p5_set_wins", int'(of_sticky), 1);
        drive(0, 2'b00, 0, 0); cycle();
        check("p5_clr_alone", int'(of_sticky), 0);
        clr_of = 1'b0;

        // 6: reset while holding a result with ACC=30
        do_reset();
        drive(1, 2'b00, 20, 15); cycle();
        drive(1, 2'b10, 10, 0); cycle(); cycle(); cycle();
        check("p6_acc30", int'(y), 30);
        check("p6_sticky_pre", int'(of_sticky), 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("p6_rst_valid", int'(out_valid), 0);
        check("p6_rst_y", int'(y), 0);
        check("p6_rst_sticky", int'(of_sticky), 0);
        drive(1, 2'b10, 1, 0); cycle();
        check("p6_acc_init", int'(y), ACC_INIT + 1);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(99, 0) < 75);
            sel       = 2'($urandom_range(3, 0));
            a         = W'($urandom_range((1 << W) - 1, 0));
            b         = W'($urandom_range((1 << W) - 1, 0));
            out_ready = ($urandom_range(99, 0) < 70);
            clr_of    = ($urandom_range(99, 0) < 10);
            rst       = ($urandom_range(999, 0) < 5);
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_of = 1'b0;
        cycle();

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_sum_rest_acc.md
Name: mod_sum_rest_acc

Overview:
- Parametrised, registered signed add/subtract unit. It is the next generation of the 6-bit combinational sum/rest block.
- Adds:
  - WIDTH generalisation
  - valid/ready handshake with one output register stage
  - internal accumulator modes
  - per-result and sticky overflow flags
- Sits between the operand source and the ALU result mux; the ALU top instantiates it with WIDTH=6 by default.

Parameters:
- WIDTH, 6: operand/result width, two's-complement signed, minimum 2.
- ACC_INIT, 0: accumulator value loaded on reset, WIDTH bits signed.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous reset, active-high
- IN_VALID  in  1  operands/op valid
- IN_READY  out  1  block can accept this cycle
- SEL  in  2  op: 00 Y=A+B, 01 Y=A-B, 10 ACC=ACC+A, 11 ACC=ACC-A
- A  in  WIDTH  signed operand A
- B  in  WIDTH  signed operand B (ignored for SEL=1x)
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- Y  out  WIDTH  signed result (for SEL=1x: new accumulator value)
- OF_SUM_REST  out  1  signed overflow of the result currently held in Y
- OF_STICKY  out  1  set on any accepted overflowing op, held until cleared
- CLR_OF  in  1  clears OF_STICKY

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). Every register is updated only on the rising edge of CLK.
- Reset values:
  - Y=0, OUT_VALID=0, OF_SUM_REST=0, OF_STICKY=0
  - accumulator=ACC_INIT
- RST overrides all other inputs in the same cycle. Reset mid-operation drops any held result with no output handshake.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational and has no dependency on IN_VALID.
- Accept: IN_VALID && IN_READY at a clock edge.
  - Next cycle: OUT_VALID=1, and Y/OF_SUM_REST hold the result.
  - Latency is exactly 1 cycle.
  - Throughput is 1 op/cycle while OUT_READY=1.
- Output hold: while OUT_VALID && !OUT_READY, Y, OF_SUM_REST and OUT_VALID stay stable and no new op is accepted.
- OUT_VALID falls after OUT_READY && OUT_VALID if no new op is accepted in the same cycle. If a new op is accepted in the same cycle, OUT_VALID stays 1 and Y updates.
- Arithmetic:
  - Computed at WIDTH bits with wrap-around (mod 2^WIDTH).
  - Add overflow: operand signs equal and result sign differs.
  - Sub overflow: operand signs differ and result sign differs from the minuend.
  - For SEL=1x the operands are (ACC, A).
- Accumulator:
  - Updated only on accept with SEL=1x; the new value is written to both the accumulator and Y.
  - SEL=0x never modifies the accumulator.
- OF_STICKY:
  - Set on the edge where an overflowing op is accepted.
  - CLR_OF clears it.
  - If CLR_OF and an overflowing accept occur in the same cycle, set wins.
- Boundaries:
  - A-B with B=-2^(WIDTH-1) follows the sub overflow rule; no special case.
  - ACC wrap follows the same rules as Y.

Optional Feature:
- Macro: MOD_SUM_REST_SATURATE_EN.
- Defined: on overflow, Y clamps to +2^(WIDTH-1)-1 if the true result is positive, else to -2^(WIDTH-1). The accumulator clamps identically, and OF_SUM_REST/OF_STICKY still assert.
- Undefined: wrap-around as described in Behaviour. No saturation logic is synthesised.

Decomposition:
- Package sum_rest_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC_ADD=2'b10, OP_ACC_SUB=2'b11
  - a function or constant returning max/min signed value for a width
- Sub-module sum_rest_core:
  - Purely combinational WIDTH-bit add/sub with overflow output and optional saturation.
  - Instantiated once.
  - Operand mux (B vs ACC) and all registers/handshake stay in the top.

Test Plan (WIDTH=6, OUT_READY=1 unless stated):
1. SEL=00, A=20, B=15 accepted -> next cycle OUT_VALID=1, Y=-29, OF_SUM_REST=1, OF_STICKY=1. With MOD_SUM_REST_SATURATE_EN: Y=31.
2. SEL=01, A=-20, B=15 -> Y=29, OF_SUM_REST=1. With MOD_SUM_REST_SATURATE_EN: Y=-32. Then SEL=01, A=5, B=-3 -> Y=8, OF_SUM_REST=0, OF_STICKY stays 1.
3. Accumulate: SEL=10, A=10 three back-to-back cycles -> Y=10, 20, 30 on consecutive cycles. Then A=5 -> Y=-29, OF=1. Then SEL=00, A=1, B=1 -> Y=2 and the accumulator stays -29.
4. Backpressure: accept A=3, B=4 add, then hold OUT_READY=0 for 3 cycles with IN_VALID=1 and new operands -> Y=7 stable, IN_READY=0, no accept. Raise OUT_READY -> pending op accepted the same cycle and the result appears the next cycle.
5. CLR_OF with an overflowing accept in the same cycle -> OF_STICKY remains 1. CLR_OF alone the next cycle -> OF_STICKY=0.
6. RST asserted one cycle while OUT_VALID=1 and ACC=30 -> next cycle OUT_VALID=0, Y=0, OF flags 0. Then SEL=10, A=1 -> Y=ACC_INIT+1.
